program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - three-state HALT/FETCH/EXEC instruction sequencer with PC, IR and address mux
module program_sequencer (
    input  logic       clk,
    input  logic       resetN,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] dbus,
    input  logic [7:0] xreg,
    input  logic       immediate,
    input  logic       doJump,
    output logic [7:0] ir,
    output logic [7:0] pc,
    output logic [7:0] addr,
    output logic       exec,
    output logic       fetch,
    output logic       halted
);

    // One-hot encoding so the status outputs are plain register bits.
    typedef enum logic [2:0] {
        S_HALT  = 3'b001,
        S_FETCH = 3'b010,
        S_EXEC  = 3'b100
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_HALT: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
                ir_d    = dbus;
                pc_d    = pc_q + 8'd1;
            end
            S_EXEC: begin
                state_d = run ? S_FETCH : S_HALT;
                // A jump overrides the operand-skip increment.
                if (doJump) begin
                    pc_d = dbus;
                end else if (immediate) begin
                    pc_d = pc_q + 8'd1;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_HALT;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign halted = state_q[0];
    assign fetch  = state_q[1];
    assign exec   = state_q[2];
    assign pc     = pc_q;
    assign ir     = ir_q;
    assign addr   = (exec && !immediate) ? xreg : pc_q;

endmodule
